// File: rtl/parking_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : parking_occupancy_counter
// Purpose  : Counts the cars in a parking lot from its entry and exit gate
//            sensors. Sensors are synchronised and sampled on a prescaled
//            clock-enable tick. A rising edge of the filtered level is one
//            event. The count saturates at 0 and at CAPACITY. Full, empty and
//            free-slot status is registered together with the count.
// Config   : `define PARK_DEBOUNCE_EN adds a per-channel debounce filter.
//            A level change must then hold for DEBOUNCE_TICKS consecutive
//            ticks. When the macro is undefined the filtered level copies the
//            synchronised level on every tick.
// Ports    : clock        in   system clock, posedge
//            reset        in   synchronous, active-high
//            enter_in     in   entry-gate sensor (async level, 1 = car)
//            exit_in      in   exit-gate sensor (async level, 1 = car)
//            clear        in   synchronous operator count clear
//            count        out  cars inside               [COUNT_WIDTH]
//            free_slots   out  CAPACITY - count          [COUNT_WIDTH]
//            full         out  count == CAPACITY
//            empty        out  count == 0
//            entry_denied out  1-cycle pulse, entry event while full
//            exit_error   out  1-cycle pulse, exit event while empty
// Revision : 1.0  initial release
// ============================================================================
module parking_occupancy_counter #(
    parameter int COUNT_WIDTH    = 8,
    parameter int CAPACITY       = 200,
    parameter int PRESCALE       = 4,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enter_in,
    input  logic                   exit_in,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] free_slots,
    output logic                   full,
    output logic                   empty,
    output logic                   entry_denied,
    output logic                   exit_error
);

    localparam int                     c_presc_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_presc_w-1:0]   c_presc_last = c_presc_w'(PRESCALE - 1);
    localparam logic [COUNT_WIDTH-1:0] c_capacity   = COUNT_WIDTH'(CAPACITY);

    // Channel index: bit 0 = entry gate, bit 1 = exit gate.
    logic [1:0]           r_meta;
    logic [1:0]           r_sync;
    logic [c_presc_w-1:0] r_presc;
    logic                 w_tick;
    logic [1:0]           w_filt;
    logic [1:0]           r_filt_d;
    logic [1:0]           w_event;

    // Two-flop synchronisers for the asynchronous sensor levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= {exit_in, enter_in};
            r_sync <= r_meta;
        end
    end

    // Free-running prescaler. The tick is a clock enable and not a derived clock.
    assign w_tick = (r_presc == c_presc_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef PARK_DEBOUNCE_EN
    typedef enum logic [0:0] {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } deb_state_t;

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_TICKS - 1);

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        deb_state_t         r_state;
        deb_state_t         w_state_next;
        logic [c_cnt_w-1:0] r_cnt;
        logic [c_cnt_w-1:0] w_cnt_next;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_state <= STABLE_LO;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
            end
        end

        // The run counter counts consecutive ticks on which the input
        // disagrees with the stable state. Agreement on any tick restarts it.
        always_comb begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            if (w_tick) begin
                case (r_state)
                    STABLE_LO: begin
                        if (r_sync[gi]) begin
                            if (r_cnt == c_deb_last) begin
                                w_state_next = STABLE_HI;
                                w_cnt_next   = '0;
                            end else begin
                                w_cnt_next = r_cnt + 1'b1;
                            end
                        end else begin
                            w_cnt_next = '0;
                        end
                    end
                    STABLE_HI: begin
                        if (!r_sync[gi]) begin
                            if (r_cnt == c_deb_last) begin
                                w_state_next = STABLE_LO;
                                w_cnt_next   = '0;
                            end else begin
                                w_cnt_next = r_cnt + 1'b1;
                            end
                        end else begin
                            w_cnt_next = '0;
                        end
                    end
                endcase
            end
        end

        assign w_filt[gi] = (r_state == STABLE_HI);
    end
`else
    localparam int c_unused_debounce = DEBOUNCE_TICKS;

    logic [1:0] r_level;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= 2'b00;
        end else if (w_tick) begin
            r_level <= r_sync;
        end
    end

    assign w_filt = r_level;
`endif

    // Edge detector. The strobe is high in the cycle after the tick that
    // raised the filtered level. Clear leaves this register alone, so a
    // sensor held high does not produce a second event after a clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_filt_d <= 2'b00;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    assign w_event = w_filt & ~r_filt_d;

    logic [COUNT_WIDTH-1:0] w_count_next;
    logic                   w_denied_next;
    logic                   w_error_next;

    // Simultaneous entry and exit events cancel out, even at 0 and at CAPACITY.
    always_comb begin
        w_count_next  = count;
        w_denied_next = 1'b0;
        w_error_next  = 1'b0;
        if (clear) begin
            w_count_next = '0;
        end else begin
            case (w_event)
                2'b01: begin
                    if (count < c_capacity) begin
                        w_count_next = count + 1'b1;
                    end else begin
                        w_denied_next = 1'b1;
                    end
                end
                2'b10: begin
                    if (count != '0) begin
                        w_count_next = count - 1'b1;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
                default: begin
                    w_count_next = count;
                end
            endcase
        end
    end

    // Status outputs are derived from the same next-count value, so they are
    // always consistent with the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            free_slots   <= c_capacity;
            full         <= 1'b0;
            empty        <= 1'b1;
            entry_denied <= 1'b0;
            exit_error   <= 1'b0;
        end else begin
            count        <= w_count_next;
            free_slots   <= c_capacity - w_count_next;
            full         <= (w_count_next == c_capacity);
            empty        <= (w_count_next == '0);
            entry_denied <= w_denied_next;
            exit_error   <= w_error_next;
        end
    end

endmodule
`default_nettype wire
